// File: rtl/gsim_pkg.sv
// Shared types and default dimensions for the Gauss-Seidel solver sequencer.
// Pure declarations: no latency, no flow control.
package gsim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_DRAIN,
        ST_OUT
    } gsim_state_t;

    localparam int GSIM_N_UNK      = 16;
    localparam int GSIM_PIPE_LAT   = 8;
    localparam int GSIM_NUM_SWEEPS = 64;

endpackage

// File: rtl/valid_delay.sv
// Delays a 1-bit valid by DEPTH cycles; empty flags that no valid is in flight.
// Latency DEPTH cycles, never stalls, async clear drops everything in flight.
module valid_delay #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic empty
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift-and-or form also holds for DEPTH=1, where the shift yields zero.
    always_comb begin
        sr_d = (sr_q << 1) | DEPTH'(d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q     = sr_q[DEPTH-1];
    assign empty = ~|sr_q;

endmodule

// File: rtl/gsim_scheduler.sv
// Sequences load, NUM_SWEEPS issue sweeps, pipeline drain and solution readout.
// Moore control (load_en is the only combinational output); in_en outside IDLE/LOAD is dropped and flagged.
module gsim_scheduler
    import gsim_pkg::*;
#(
    parameter int N_UNK      = GSIM_N_UNK,
    parameter int IDX_W      = 4,
    parameter int PIPE_LAT   = GSIM_PIPE_LAT,
    parameter int NUM_SWEEPS = GSIM_NUM_SWEEPS,
    parameter int SWP_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    output logic             load_en,
    output logic             shift_en,
    output logic             issue_en,
    output logic             wb_en,
    output logic [IDX_W-1:0] idx,
    output logic [SWP_W-1:0] sweep,
    output logic             out_valid,
    output logic             busy,
    output logic             proto_err
);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_UNK - 1);
    localparam logic [SWP_W-1:0] SWEEP_LAST = SWP_W'(NUM_SWEEPS - 1);

    gsim_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SWP_W-1:0] sweep_q, sweep_d;
    logic             proto_err_q, proto_err_d;
    logic             dl_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            sweep_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sweep_q     <= sweep_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sweep_d     = sweep_q;
        proto_err_d = proto_err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_en) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_en) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_ITER;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_ITER: begin
                // N_UNK is a power of two, so the increment wraps on its own.
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    sweep_d = sweep_q + 1'b1;
                    if (sweep_q == SWEEP_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (dl_empty) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    sweep_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (in_en && (state_q == ST_ITER || state_q == ST_DRAIN || state_q == ST_OUT)) begin
            proto_err_d = 1'b1;
        end
    end

    // Write-back timing follows issue only, so it keeps running through DRAIN.
    valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_wb_delay (
        .clk   (clk),
        .reset (reset),
        .d     (issue_en),
        .q     (wb_en),
        .empty (dl_empty)
    );

    assign load_en   = in_en && (state_q == ST_IDLE || state_q == ST_LOAD);
    assign issue_en  = (state_q == ST_ITER);
    assign out_valid = (state_q == ST_OUT);
    assign shift_en  = issue_en || out_valid;
    assign busy      = (state_q != ST_IDLE);
    assign idx       = idx_q;
    assign sweep     = sweep_q;
    assign proto_err = proto_err_q;

endmodule
